serial_adder: RTL

- Bit-serial, multi-cycle adder: the inverse operation of the team's combinational 5-bit subtractor.
- Given a difference and the subtrahend, it rebuilds the minuend: sum = a + b, modulo 2^WIDTH, plus a carry-out.
- Processes one bit per clock, LSB first, using a single full-adder and a carry flip-flop.
- Start/done handshake so the lab datapath FSM can issue an operation and wait for the result.

---
 rtl/serial_adder.sv | 79 +++++++
 1 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first adder with one full adder, start/done handshake.
module serial_adder #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, res_q, res_d, sum_q, sum_d;
  logic             carry_q, carry_d, cout_q, cout_d, s;
  logic [CW-1:0]    cnt_q, cnt_d;
  assign s    = opa_q[0] ^ opb_q[0] ^ carry_q;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign sum  = sum_q;
  assign cout = cout_q;
  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    if (state_q == IDLE && start) begin
      opa_d   = a;
      opb_d   = b;
      res_d   = '0;
      carry_d = 1'b0;
      cnt_d   = '0;
      state_d = RUN;
    end else if (state_q == RUN) begin
      opa_d   = opa_q >> 1;
      opb_d   = opb_q >> 1;
      res_d   = {s, res_q[WIDTH-1:1]};
      carry_d = (opa_q[0] & opb_q[0]) | (carry_q & (opa_q[0] ^ opb_q[0]));
      cnt_d   = cnt_q + CW'(1);
      // last bit: publish the result only now so sum/cout hold through RUN
      if (cnt_q == CW'(WIDTH - 1)) begin
        state_d = DONE;
        sum_d   = res_d;
        cout_d  = carry_d;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end
endmodule
